// File: rtl/ahb_pkg.sv
// ahb_pkg: AHB transfer/burst/response encodings shared by the arbiter files.
package ahb_pkg;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    localparam logic [2:0] HBURST_SINGLE = 3'd0;
    localparam logic [2:0] HBURST_INCR   = 3'd1;
    localparam logic [2:0] HBURST_WRAP4  = 3'd2;
    localparam logic [2:0] HBURST_INCR4  = 3'd3;
    localparam logic [2:0] HBURST_WRAP8  = 3'd4;
    localparam logic [2:0] HBURST_INCR8  = 3'd5;
    localparam logic [2:0] HBURST_WRAP16 = 3'd6;
    localparam logic [2:0] HBURST_INCR16 = 3'd7;

    localparam logic [1:0] HRESP_OKAY  = 2'b00;
    localparam logic [1:0] HRESP_ERROR = 2'b01;
    localparam logic [1:0] HRESP_RETRY = 2'b10;
    localparam logic [1:0] HRESP_SPLIT = 2'b11;

    // Beats remaining after the NONSEQ beat; undefined-length bursts count as single beats.
    function automatic logic [3:0] burst_len(input logic [2:0] hburst);
        return (hburst == HBURST_INCR4  || hburst == HBURST_WRAP4)  ? 4'd3  :
               (hburst == HBURST_INCR8  || hburst == HBURST_WRAP8)  ? 4'd7  :
               (hburst == HBURST_INCR16 || hburst == HBURST_WRAP16) ? 4'd15 : 4'd0;
    endfunction

endpackage

// File: rtl/ahb_rr_pick.sv
// ahb_rr_pick: combinational round-robin pick, searching upward from ptr+1 with wrap.
module ahb_rr_pick #(
    parameter int N = 4
) (
    input  logic [N-1:0] req,
    input  logic [3:0]   ptr,
    output logic [N-1:0] gnt,
    output logic [3:0]   idx,
    output logic         any_req
);

    int j;

    // Scan from farthest to nearest so the nearest requester overwrites the rest.
    always_comb begin
        gnt     = '0;
        idx     = ptr;
        any_req = |req;
        j       = 0;
        for (int k = N; k >= 1; k--) begin
            j = (int'(ptr) + k) % N;
            if (req[j]) begin
                gnt = N'(1) << j;
                idx = 4'(j);
            end
        end
    end

endmodule

// File: rtl/ahb_arbiter.sv
// ahb_arbiter: round-robin AHB bus arbiter with default master, burst and lock hold.
module ahb_arbiter
    import ahb_pkg::*;
#(
    parameter int NUM_MASTERS    = 4,
    parameter int DEFAULT_MASTER = 0
) (
    input  logic                   hclk,
    input  logic                   hresetn,
    input  logic [NUM_MASTERS-1:0] hbusreq,
    input  logic [NUM_MASTERS-1:0] hlock,
    input  logic [1:0]             htrans,
    input  logic [2:0]             hburst,
    input  logic                   hready,
    input  logic [1:0]             hresp,
    output logic [NUM_MASTERS-1:0] hgrant,
    output logic [3:0]             hmaster,
    output logic                   hmastlock
);

    localparam logic [3:0]             DEF_IDX = 4'(DEFAULT_MASTER);
    localparam logic [NUM_MASTERS-1:0] DEF_GNT = NUM_MASTERS'(1) << DEFAULT_MASTER;

    logic [3:0]             cnt;
    logic [3:0]             cnt_nxt;
    logic [3:0]             ptr;
    logic [3:0]             gidx;
    logic                   open;
    logic                   holder_lock;
    logic [NUM_MASTERS-1:0] pick_gnt;
    logic [3:0]             pick_idx;
    logic                   pick_any;

    ahb_rr_pick #(.N(NUM_MASTERS)) u_pick (
        .req     (hbusreq),
        .ptr     (ptr),
        .gnt     (pick_gnt),
        .idx     (pick_idx),
        .any_req (pick_any)
    );

    assign holder_lock = |(hlock & hgrant);

    // A non-OKAY response kills the burst even while hready is low.
    always_comb begin
        cnt_nxt = cnt;
        if (hresp != HRESP_OKAY)
            cnt_nxt = 4'd0;
        else if (hready)
            cnt_nxt = (htrans == HTRANS_NONSEQ) ? burst_len(hburst) :
                      (htrans == HTRANS_SEQ)    ? ((cnt != 4'd0) ? cnt - 4'd1 : 4'd0) :
                      (htrans == HTRANS_BUSY)   ? cnt : 4'd0;
        open = hready && (cnt_nxt <= 4'd1) && !holder_lock;
    end

    always_ff @(posedge hclk or negedge hresetn) begin
        if (!hresetn) begin
            cnt       <= 4'd0;
            ptr       <= DEF_IDX;
            gidx      <= DEF_IDX;
            hgrant    <= DEF_GNT;
            hmaster   <= DEF_IDX;
            hmastlock <= 1'b0;
        end else begin
            cnt <= cnt_nxt;
            if (hready) begin
                hmaster   <= gidx;
                hmastlock <= holder_lock;
            end
            if (open) begin
                hgrant <= pick_any ? pick_gnt : DEF_GNT;
                gidx   <= pick_any ? pick_idx : DEF_IDX;
                if (pick_any)
                    ptr <= pick_idx;
            end
        end
    end

endmodule

// File: tb/tb_ahb_arbiter.sv
// tb_ahb_arbiter: directed and random checks of ahb_arbiter against a behavioural model.
module tb_ahb_arbiter;

    logic       hclk = 1'b0;
    logic       hresetn;
    logic [3:0] hbusreq;
    logic [3:0] hlock;
    logic [1:0] htrans;
    logic [2:0] hburst;
    logic       hready;
    logic [1:0] hresp;
    logic [3:0] hgrant;
    logic [3:0] hmaster;
    logic       hmastlock;

    int errors = 0;
    int checks = 0;

    int m_g, m_ptr, m_cnt, m_master;
    bit m_lock;

    ahb_arbiter #(.NUM_MASTERS(4), .DEFAULT_MASTER(0)) dut (
        .hclk      (hclk),
        .hresetn   (hresetn),
        .hbusreq   (hbusreq),
        .hlock     (hlock),
        .htrans    (htrans),
        .hburst    (hburst),
        .hready    (hready),
        .hresp     (hresp),
        .hgrant    (hgrant),
        .hmaster   (hmaster),
        .hmastlock (hmastlock)
    );

    always #5 hclk = ~hclk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int beats(input logic [2:0] bu);
        case (bu)
            3'd2, 3'd3: return 4;
            3'd4, 3'd5: return 8;
            3'd6, 3'd7: return 16;
            default:    return 1;
        endcase
    endfunction

    task automatic model_reset();
        m_g = 0; m_ptr = 0; m_cnt = 0; m_master = 0; m_lock = 0;
    endtask

    // Drive one cycle of inputs, advance the model across the edge, check outputs after it.
    task automatic step(input logic [3:0] req, input logic [3:0] lk, input logic [1:0] tr,
                        input logic [2:0] bu, input logic rdy, input logic [1:0] rs);
        int nc, ng, i;
        bit open, found;
        hbusreq = req; hlock = lk; htrans = tr; hburst = bu; hready = rdy; hresp = rs;
        nc = m_cnt;
        if (rs != 2'b00) nc = 0;
        else if (rdy) begin
            if (tr == 2'b10) nc = beats(bu) - 1;
            else if (tr == 2'b11) nc = (m_cnt > 0) ? m_cnt - 1 : 0;
            else if (tr == 2'b00) nc = 0;
        end
        open = rdy && nc <= 1 && !lk[m_g];
        if (rdy) begin
            m_master = m_g;
            m_lock = lk[m_g];
        end
        if (open) begin
            found = 0; ng = 0;
            for (int k = 1; k <= 4; k++) begin
                i = (m_ptr + k) % 4;
                if (!found && req[i]) begin found = 1; ng = i; end
            end
            if (found) begin m_g = ng; m_ptr = ng; end
            else m_g = 0;
        end
        m_cnt = nc;
        @(posedge hclk); #1;
        chk("hgrant", 32'(hgrant), 32'(4'b0001 << m_g));
        chk("hmaster", 32'(hmaster), 32'(m_master));
        chk("hmastlock", 32'(hmastlock), 32'(m_lock));
        @(negedge hclk);
    endtask

    initial begin
        hresetn = 1'b0; hbusreq = '0; hlock = '0; htrans = '0; hburst = '0; hready = 1'b1; hresp = '0;
        model_reset();
        repeat (2) @(negedge hclk);
        chk("rst_grant", 32'(hgrant), 32'h1);
        chk("rst_master", 32'(hmaster), 32'h0);
        chk("rst_lock", 32'(hmastlock), 32'h0);
        hresetn = 1'b1;
        @(negedge hclk);

        // round robin among M1, M2 with single transfers
        step(4'b0110, 4'b0, 2'b10, 3'd0, 1'b1, 2'b00);
        chk("rr_g1", 32'(hgrant), 32'b0010);
        step(4'b0110, 4'b0, 2'b10, 3'd0, 1'b1, 2'b00);
        chk("rr_g2", 32'(hgrant), 32'b0100);
        chk("rr_m2", 32'(hmaster), 32'd1);
        step(4'b0110, 4'b0, 2'b10, 3'd0, 1'b1, 2'b00);
        chk("rr_g3", 32'(hgrant), 32'b0010);
        chk("rr_m3", 32'(hmaster), 32'd2);

        // M1 INCR4, M2 waiting
        step(4'b0100, 4'b0, 2'b10, 3'd3, 1'b1, 2'b00);
        chk("b4_beat1", 32'(hgrant), 32'b0010);
        step(4'b0100, 4'b0, 2'b11, 3'd3, 1'b1, 2'b00);
        chk("b4_beat2", 32'(hgrant), 32'b0010);
        step(4'b0100, 4'b0, 2'b11, 3'd3, 1'b1, 2'b00);
        chk("b4_beat3", 32'(hgrant), 32'b0100);
        step(4'b0100, 4'b0, 2'b11, 3'd3, 1'b1, 2'b00);
        chk("b4_beat4_master", 32'(hmaster), 32'd2);

        // M2 INCR4 with wait states and BUSY, M3 waiting
        step(4'b1000, 4'b0, 2'b10, 3'd3, 1'b1, 2'b00);
        step(4'b1000, 4'b0, 2'b11, 3'd3, 1'b0, 2'b00);
        step(4'b1000, 4'b0, 2'b11, 3'd3, 1'b0, 2'b00);
        chk("ws_hold", 32'(hgrant), 32'b0100);
        step(4'b1000, 4'b0, 2'b11, 3'd3, 1'b1, 2'b00);
        step(4'b1000, 4'b0, 2'b01, 3'd3, 1'b1, 2'b00);
        chk("ws_busy", 32'(hgrant), 32'b0100);
        step(4'b1000, 4'b0, 2'b11, 3'd3, 1'b1, 2'b00);
        chk("ws_switch", 32'(hgrant), 32'b1000);
        step(4'b1000, 4'b0, 2'b11, 3'd3, 1'b1, 2'b00);
        chk("ws_master", 32'(hmaster), 32'd3);

        // M3 locked against all requesters
        for (int n = 0; n < 6; n++) begin
            step(4'b1111, 4'b1000, 2'b10, 3'd0, 1'b1, 2'b00);
            chk("lock_grant", 32'(hgrant), 32'b1000);
            chk("lock_mastlock", 32'(hmastlock), 32'd1);
        end
        step(4'b1111, 4'b0000, 2'b10, 3'd0, 1'b1, 2'b00);
        chk("unlock_grant", 32'(hgrant), 32'b0001);

        // M0 INCR8 terminated by a two-cycle ERROR
        step(4'b0011, 4'b0, 2'b10, 3'd5, 1'b1, 2'b00);
        step(4'b0011, 4'b0, 2'b11, 3'd5, 1'b1, 2'b00);
        step(4'b0011, 4'b0, 2'b11, 3'd5, 1'b1, 2'b00);
        step(4'b0011, 4'b0, 2'b11, 3'd5, 1'b0, 2'b01);
        chk("err_cycle1", 32'(hgrant), 32'b0001);
        step(4'b0011, 4'b0, 2'b00, 3'd5, 1'b1, 2'b01);
        chk("err_rearb", 32'(hgrant), 32'b0010);

        // asynchronous reset in the middle of an M1 INCR16
        step(4'b0010, 4'b0, 2'b10, 3'd7, 1'b1, 2'b00);
        step(4'b0010, 4'b0, 2'b11, 3'd7, 1'b1, 2'b00);
        #2 hresetn = 1'b0;
        #1;
        chk("arst_grant", 32'(hgrant), 32'h1);
        chk("arst_master", 32'(hmaster), 32'h0);
        chk("arst_lock", 32'(hmastlock), 32'h0);
        @(negedge hclk);
        hresetn = 1'b1;
        model_reset();

        for (int n = 0; n < 400; n++) begin
            logic [3:0] rq, lk;
            rq = 4'($urandom);
            lk = ($urandom_range(0, 5) == 0) ? (4'($urandom) & rq) : 4'b0;
            step(rq, lk, 2'($urandom), 3'($urandom), $urandom_range(0, 3) != 0,
                 ($urandom_range(0, 9) == 0) ? 2'($urandom) : 2'b00);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
